// File: rtl/card_match_ctrl.sv
// Game logic for the 4x4 memory game: cursor, pick/compare FSM, mismatch flip-back timer, move/pair counters.
// Optional macro CARD_FAST_FLIP_EN: btn_sel during the mismatch wait flips both cards down on the next edge.
module card_match_ctrl #(
  parameter int unsigned MISMATCH_TICKS = 50000000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game_i,
  input  logic [47:0] card_map_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_sel_i,
  output logic [3:0]  cursor_o,
  output logic [15:0] face_up_o,
  output logic [15:0] matched_o,
  output logic [3:0]  pairs_found_o,
  output logic [7:0]  moves_o,
  output logic        busy_o,
  output logic        game_over_o
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_ONE_UP        = 3'd1,
    S_CHECK         = 3'd2,
    S_MISMATCH_WAIT = 3'd3,
    S_WIN           = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(MISMATCH_TICKS - 1);

  state_t           state_q, state_d;
  logic [3:0]       cursor_q, cursor_d;
  logic [3:0]       first_q, first_d;
  logic [3:0]       second_q, second_d;
  logic [3:0]       pairs_q, pairs_d;
  logic [15:0]      face_up_q, face_up_d;
  logic [15:0]      matched_q, matched_d;
  logic [7:0]       moves_q, moves_d;
  logic [47:0]      map_q, map_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             game_over_q, game_over_d;

  logic             sel_ok;
  logic [2:0]       id_first, id_second;
  logic             flip_back;

  assign sel_ok    = btn_sel_i && !face_up_q[cursor_q] && !matched_q[cursor_q];
  assign id_first  = map_q[{2'b00, first_q} * 6'd3 +: 3];
  assign id_second = map_q[{2'b00, second_q} * 6'd3 +: 3];

`ifdef CARD_FAST_FLIP_EN
  assign flip_back = (timer_q == TIMER_LAST) || btn_sel_i;
`else
  assign flip_back = (timer_q == TIMER_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    first_d   = first_q;
    second_d  = second_q;
    pairs_d   = pairs_q;
    face_up_d = face_up_q;
    matched_d = matched_q;
    moves_d   = moves_q;
    map_d     = map_q;
    timer_d   = timer_q;

    if (new_game_i) begin
      state_d   = S_IDLE;
      cursor_d  = 4'd0;
      first_d   = 4'd0;
      second_d  = 4'd0;
      pairs_d   = 4'd0;
      face_up_d = 16'd0;
      matched_d = 16'd0;
      moves_d   = 8'd0;
      map_d     = card_map_i;
      timer_d   = '0;
    end else begin
      // A select in the same cycle pins the cursor so the pick uses the pre-move position.
      if (!btn_sel_i) begin
        if (btn_up_i)         cursor_d = {cursor_q[3:2] - 2'd1, cursor_q[1:0]};
        else if (btn_down_i)  cursor_d = {cursor_q[3:2] + 2'd1, cursor_q[1:0]};
        else if (btn_left_i)  cursor_d = {cursor_q[3:2], cursor_q[1:0] - 2'd1};
        else if (btn_right_i) cursor_d = {cursor_q[3:2], cursor_q[1:0] + 2'd1};
      end

      case (state_q)
        S_IDLE: begin
          if (sel_ok) begin
            face_up_d[cursor_q] = 1'b1;
            first_d             = cursor_q;
            state_d             = S_ONE_UP;
          end
        end
        S_ONE_UP: begin
          if (sel_ok) begin
            face_up_d[cursor_q] = 1'b1;
            second_d            = cursor_q;
            moves_d             = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            state_d             = S_CHECK;
          end
        end
        S_CHECK: begin
          if (id_first == id_second) begin
            matched_d[first_q]  = 1'b1;
            matched_d[second_q] = 1'b1;
            pairs_d             = pairs_q + 4'd1;
            state_d             = (pairs_q == 4'd7) ? S_WIN : S_IDLE;
          end else begin
            timer_d = '0;
            state_d = S_MISMATCH_WAIT;
          end
        end
        S_MISMATCH_WAIT: begin
          if (flip_back) begin
            face_up_d[first_q]  = 1'b0;
            face_up_d[second_q] = 1'b0;
            state_d             = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_WIN: begin
          state_d = S_WIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d      = (state_d == S_CHECK) || (state_d == S_MISMATCH_WAIT);
    game_over_d = (state_d == S_WIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cursor_q    <= 4'd0;
      first_q     <= 4'd0;
      second_q    <= 4'd0;
      pairs_q     <= 4'd0;
      face_up_q   <= 16'd0;
      matched_q   <= 16'd0;
      moves_q     <= 8'd0;
      map_q       <= 48'd0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      first_q     <= first_d;
      second_q    <= second_d;
      pairs_q     <= pairs_d;
      face_up_q   <= face_up_d;
      matched_q   <= matched_d;
      moves_q     <= moves_d;
      map_q       <= map_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign cursor_o      = cursor_q;
  assign face_up_o     = face_up_q;
  assign matched_o     = matched_q;
  assign pairs_found_o = pairs_q;
  assign moves_o       = moves_q;
  assign busy_o        = busy_q;
  assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_card_match_ctrl.sv
// Directed bench for card_match_ctrl with a 4-cycle mismatch wait; expected snapshots are queued then drained.
module tb_card_match_ctrl;

  logic        clk;
  logic        rst_n;
  logic        new_game;
  logic [47:0] card_map;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [3:0]  cursor;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        busy;
  logic        game_over;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [3:0]  cur;
    logic [15:0] fu;
    logic [15:0] mt;
    logic [3:0]  pf;
    logic [7:0]  mv;
    logic        bz;
    logic        go;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] IDS_BASE = 64'h7766554433221100;
  localparam logic [63:0] IDS_M3   = 64'h7766554433110022;
  localparam logic [63:0] IDS_M4   = 64'h7766443322001551;

  card_match_ctrl #(
    .MISMATCH_TICKS(4),
    .CNT_W         (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game_i   (new_game),
    .card_map_i   (card_map),
    .btn_up_i     (btn_up),
    .btn_down_i   (btn_down),
    .btn_left_i   (btn_left),
    .btn_right_i  (btn_right),
    .btn_sel_i    (btn_sel),
    .cursor_o     (cursor),
    .face_up_o    (face_up),
    .matched_o    (matched),
    .pairs_found_o(pairs_found),
    .moves_o      (moves),
    .busy_o       (busy),
    .game_over_o  (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, assertions=%0d failures=%0d", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] mk_map(input logic [63:0] ids);
    logic [47:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[3*i +: 3] = ids[4*i +: 3];
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic s);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
  endtask

  task automatic ng(input logic [63:0] ids);
    card_map = mk_map(ids);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic sb_push(input string tag, input logic [3:0] cur, input logic [15:0] fu,
                         input logic [15:0] mt, input logic [3:0] pf, input logic [7:0] mv,
                         input logic bz, input logic go);
    exp_t e;
    e.tag = tag; e.cur = cur; e.fu = fu; e.mt = mt; e.pf = pf; e.mv = mv; e.bz = bz; e.go = go;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
    end
  endtask

  task automatic chk();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "cursor",    {12'd0, cursor},      {12'd0, e.cur});
      cmp(e.tag, "face_up",   face_up,              e.fu);
      cmp(e.tag, "matched",   matched,              e.mt);
      cmp(e.tag, "pairs",     {12'd0, pairs_found}, {12'd0, e.pf});
      cmp(e.tag, "moves",     {8'd0, moves},        {8'd0, e.mv});
      cmp(e.tag, "busy",      {15'd0, busy},        {15'd0, e.bz});
      cmp(e.tag, "game_over", {15'd0, game_over},   {15'd0, e.go});
    end
  endtask

  initial begin
    rst_n = 1'b0; new_game = 1'b0; card_map = '0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: reset in the middle of a check
    ng(IDS_BASE);
    press(0, 0, 0, 0, 1);
    sb_push("t1_pick", 4'd0, 16'h0001, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    sb_push("t1_check", 4'd1, 16'h0003, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    rst_n = 1'b0;
    #1;
    sb_push("t1_rst_low", 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    sb_push("t1_rst_rel", 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    ng(IDS_BASE);
    sb_push("t1_newgame", 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0); chk();

    // 2: cursor wrap and priority
    press(0, 0, 1, 0, 0); sb_push("t2_left_wrap", 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 0, 0, 1, 0); sb_push("t2_right_wrap", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(1, 0, 0, 0, 0); sb_push("t2_up_wrap", 4'd12, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 1, 0, 0, 0); sb_push("t2_down_wrap", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0); sb_push("t2_at5", 4'd5, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(1, 0, 0, 1, 0); sb_push("t2_up_right", 4'd1, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 1, 1, 1, 0); sb_push("t2_down_left", 4'd5, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 0, 1, 1, 0); sb_push("t2_left_right", 4'd4, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 1); sb_push("t2_sel_move", 4'd0, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();

    // 3: a matching pair
    ng(IDS_M3);
    sb_push("t3_newgame", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    sb_push("t3_check", 4'd1, 16'h0003, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    tick(1);
    sb_push("t3_matched", 4'd1, 16'h0003, 16'h0003, 4'd1, 8'd1, 1'b0, 1'b0); chk();
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    sb_push("t3_resel", 4'd0, 16'h0003, 16'h0003, 4'd1, 8'd1, 1'b0, 1'b0); chk();

    // 4: mismatch wait and flip-back
    ng(IDS_M4);
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    sb_push("t4_check", 4'd2, 16'h0005, 16'h0, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    tick(1);
    sb_push("t4_wait0", 4'd2, 16'h0005, 16'h0, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    press(0, 0, 0, 0, 1);
`ifdef CARD_FAST_FLIP_EN
    sb_push("t4_fast_flip", 4'd2, 16'h0000, 16'h0, 4'd0, 8'd1, 1'b0, 1'b0); chk();
`else
    sb_push("t4_sel_ignored", 4'd2, 16'h0005, 16'h0, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    tick(2);
    sb_push("t4_wait_last", 4'd2, 16'h0005, 16'h0, 4'd0, 8'd1, 1'b1, 1'b0); chk();
    tick(1);
    sb_push("t4_flip", 4'd2, 16'h0000, 16'h0, 4'd0, 8'd1, 1'b0, 1'b0); chk();
`endif
    press(0, 0, 0, 0, 1);
    sb_push("t4_idle_again", 4'd2, 16'h0004, 16'h0, 4'd0, 8'd1, 1'b0, 1'b0); chk();

    // 5: solve the whole board
    ng(IDS_BASE);
    for (int p = 0; p < 8; p++) begin
      press(0, 0, 0, 0, 1);
      press(0, 0, 0, 1, 0);
      press(0, 0, 0, 0, 1);
      tick(1);
      sb_push($sformatf("t5_pair%0d", p), 4'(2*p+1), 16'((32'd1 << (2*p+2)) - 32'd1),
              16'((32'd1 << (2*p+2)) - 32'd1), 4'(p+1), 8'(p+1), 1'b0, (p == 7));
      chk();
      if (p < 7) begin
        press(0, 0, 0, 1, 0);
        if (((2*p+1) % 4) == 3) press(0, 1, 0, 0, 0);
      end
    end
    press(0, 0, 0, 0, 1);
    sb_push("t5_win_sel", 4'd15, 16'hFFFF, 16'hFFFF, 4'd8, 8'd8, 1'b0, 1'b1); chk();
    press(0, 0, 1, 0, 0);
    sb_push("t5_win_move", 4'd14, 16'hFFFF, 16'hFFFF, 4'd8, 8'd8, 1'b0, 1'b1); chk();
    ng(IDS_BASE);
    sb_push("t5_cleared", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();

    // 6: move counter saturation, then new_game racing a check
    ng(IDS_M4);
    for (int i = 0; i < 260; i++) begin
      press(0, 0, 0, 0, 1);
      if ((i % 2) == 0) press(0, 0, 0, 1, 0);
      else              press(0, 0, 1, 0, 0);
      press(0, 0, 0, 0, 1);
      tick(5);
      if (i == 0 || i == 254 || i == 259) begin
        sb_push($sformatf("t6_moves_i%0d", i), ((i % 2) == 0) ? 4'd1 : 4'd0, 16'h0, 16'h0, 4'd0,
                (i == 0) ? 8'd1 : 8'd255, 1'b0, 1'b0);
        chk();
      end
    end
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    sb_push("t6_check", 4'd2, 16'h0006, 16'h0, 4'd0, 8'd255, 1'b1, 1'b0); chk();
    card_map = mk_map(IDS_M4);
    new_game = 1'b1;
    btn_sel  = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    btn_sel  = 1'b0;
    sb_push("t6_ng_in_check", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();
    tick(1);
    sb_push("t6_no_late_match", 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0); chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
